// File: rtl/hack_control_unit_pkg.sv
// Shared definitions for the Hack CPU controller: FSM states, instruction
// field positions and the ALU "constant 0" control pattern.
package hack_control_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEMWAIT
    } state_e;

    // Instruction field positions
    localparam int unsigned IR_CI      = 15; // 1 = C-instruction
    localparam int unsigned IR_AM      = 12; // ALU Y operand: 0=A, 1=M
    localparam int unsigned IR_COMP_HI = 11; // zx..no = IR[11:6]
    localparam int unsigned IR_COMP_LO = 6;
    localparam int unsigned IR_D1      = 5;  // dest A
    localparam int unsigned IR_D2      = 4;  // dest D
    localparam int unsigned IR_D3      = 3;  // dest M
    localparam int unsigned IR_JUMP_HI = 2;  // j1 j2 j3 = IR[2:0]
    localparam int unsigned IR_JUMP_LO = 0;

    // ALU controls that produce the constant 0
    localparam logic [5:0] COMP_ZERO = 6'b101010;

endpackage

// File: rtl/hack_jump_eval.sv
// Combinational jump-condition evaluator.
//   j[2:0]  in   jump field {j1,j2,j3}: jump on <0, ==0, >0
//   zr, ng  in   ALU flags (out==0, out<0)
//   jump    out  1 when the selected condition holds
module hack_jump_eval (
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       jump
);

    always_comb begin
        jump = (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
    end

endmodule

// File: rtl/hack_control_unit.sv
// Multi-cycle Hack CPU controller. Accepts one instruction per valid/ready
// handshake, decodes it and issues one-cycle commit strobes to the A/D
// registers, data memory and PC. With MEM_HANDSHAKE=1 a memory write is held
// until mem_ack or aborted after MEM_TIMEOUT wait cycles.
//   clk, rst_n                 clock, async active-low reset
//   instr, instr_valid         instruction input / valid
//   instr_ready                high in FETCH
//   zr, ng                     ALU flags
//   zx,nx,zy,ny,f,no           ALU controls (from registered IR)
//   a_sel, a_src               ALU Y source (A/M), A-register input (IR/ALU)
//   load_a, load_d, write_m,
//   pc_load, pc_inc            commit strobes
//   mem_ack                    memory write accepted
//   mem_err                    one-cycle pulse on ack timeout
//   retired                    committed-instruction counter (wraps)
module hack_control_unit
    import hack_control_unit_pkg::*;
#(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned MEM_TIMEOUT   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        zr,
    input  logic        ng,
    output logic        zx,
    output logic        nx,
    output logic        zy,
    output logic        ny,
    output logic        f,
    output logic        no,
    output logic        a_sel,
    output logic        a_src,
    output logic        load_a,
    output logic        load_d,
    output logic        write_m,
    output logic        pc_load,
    output logic        pc_inc,
    input  logic        mem_ack,
    output logic        mem_err,
    output logic [15:0] retired
);

    localparam int unsigned TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [15:0]       retired_q, retired_d;
    logic              mem_err_q, mem_err_d;

    logic              is_c;
    logic              jump;
    logic              commit;
    logic              unused_ir;

    assign is_c      = ir_q[IR_CI];
    assign unused_ir = ^ir_q[14:13];

    hack_jump_eval u_jump (
        .j    (ir_q[IR_JUMP_HI:IR_JUMP_LO]),
        .zr   (zr),
        .ng   (ng),
        .jump (jump)
    );

    // ALU controls depend only on the registered IR
    assign {zx, nx, zy, ny, f, no} = is_c ? ir_q[IR_COMP_HI:IR_COMP_LO] : COMP_ZERO;
    assign a_sel   = ir_q[IR_AM];
    assign a_src   = is_c;
    assign mem_err = mem_err_q;
    assign retired = retired_q;

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        tmo_d       = tmo_q;
        retired_d   = retired_q;
        mem_err_d   = 1'b0;
        instr_ready = 1'b0;
        commit      = 1'b0;
        load_a      = 1'b0;
        load_d      = 1'b0;
        write_m     = 1'b0;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Handshaked write: EXEC stays silent, MEMWAIT carries the write
                if (MEM_HANDSHAKE && is_c && ir_q[IR_D3]) begin
                    tmo_d   = '0;
                    state_d = ST_MEMWAIT;
                end else begin
                    commit  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_MEMWAIT: begin
                write_m = 1'b1;
                if (mem_ack) begin
                    commit  = 1'b1;
                    state_d = ST_FETCH;
                end else if (tmo_q == TMO_LAST) begin
                    // Abort: error shows in the following (FETCH) cycle
                    mem_err_d = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        if (commit) begin
            retired_d = retired_q + 16'd1;
            if (is_c) begin
                load_a  = ir_q[IR_D1];
                load_d  = ir_q[IR_D2];
                write_m = write_m | ir_q[IR_D3];
                pc_load = jump;
                pc_inc  = ~jump;
            end else begin
                load_a = 1'b1;
                pc_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            ir_q      <= '0;
            tmo_q     <= '0;
            retired_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            tmo_q     <= tmo_d;
            retired_q <= retired_d;
            mem_err_q <= mem_err_d;
        end
    end

endmodule

// File: tb/tb_hack_control_unit.sv
module tb_hack_control_unit;

    localparam bit HANDSHAKE = 1'b1;
    localparam int TMO       = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        zr, ng;
    logic        zx, nx, zy, ny, f, no;
    logic        a_sel, a_src;
    logic        load_a, load_d, write_m, pc_load, pc_inc;
    logic        mem_ack;
    logic        mem_err;
    logic [15:0] retired;

    int checks = 0;
    int errors = 0;
    int retired_exp = 0;

    hack_control_unit #(
        .MEM_HANDSHAKE (HANDSHAKE),
        .MEM_TIMEOUT   (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .zr          (zr),
        .ng          (ng),
        .zx          (zx),
        .nx          (nx),
        .zy          (zy),
        .ny          (ny),
        .f           (f),
        .no          (no),
        .a_sel       (a_sel),
        .a_src       (a_src),
        .load_a      (load_a),
        .load_d      (load_d),
        .write_m     (write_m),
        .pc_load     (pc_load),
        .pc_inc      (pc_inc),
        .mem_ack     (mem_ack),
        .mem_err     (mem_err),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {load_a, load_d, write_m, pc_load, pc_inc};
    endfunction

    // One instruction from FETCH back to FETCH. flag_sel: 0=negative result,
    // 1=zero result, 2=positive result. ack_at: MEMWAIT cycle index that sees
    // mem_ack (out of range = never). Entered and left at a negedge in FETCH.
    task automatic do_instr(input logic [15:0] ins, input int flag_sel, input int ack_at);
        logic       c, z, n, taken, waits, acked, timed_out;
        logic [5:0] ctrl_e;
        logic [4:0] commit_e;
        n         = (flag_sel == 0);
        z         = (flag_sel == 1);
        c         = ins[15];
        ctrl_e    = c ? ins[11:6] : 6'b101010;
        // result < 0 / == 0 / > 0 selected by j1/j2/j3
        taken     = c && ((ins[2] && n) || (ins[1] && z) || (ins[0] && !n && !z));
        waits     = c && ins[3] && HANDSHAKE;
        commit_e  = c ? {ins[5], ins[4], ins[3], taken, !taken} : 5'b10001;
        acked     = 1'b0;
        timed_out = 1'b0;

        instr       = ins;
        instr_valid = 1'b1;
        zr          = 1'($urandom);
        ng          = 1'($urandom);
        mem_ack     = 1'($urandom);
        #1;
        check_eq("fetch_ready", 32'(instr_ready), 32'd1);
        check_eq("fetch_strobes", 32'(strobes()), 32'd0);

        @(negedge clk);
        instr       = 16'($urandom);
        instr_valid = 1'($urandom);
        zr          = z;
        ng          = n;
        mem_ack     = 1'($urandom);
        #1;
        check_eq("exec_ctrl", 32'({zx, nx, zy, ny, f, no}), 32'(ctrl_e));
        check_eq("exec_a_sel", 32'(a_sel), 32'(ins[12]));
        check_eq("exec_a_src", 32'(a_src), 32'(c));
        check_eq("exec_ready", 32'(instr_ready), 32'd0);
        if (!waits) begin
            check_eq("exec_commit", 32'(strobes()), 32'(commit_e));
            retired_exp++;
        end else begin
            check_eq("exec_quiet", 32'(strobes()), 32'd0);
            for (int k = 0; k < TMO && !acked; k++) begin
                @(negedge clk);
                mem_ack = (k == ack_at);
                #1;
                check_eq("wait_ready", 32'(instr_ready), 32'd0);
                if (k == ack_at) begin
                    check_eq("ack_commit", 32'(strobes()), 32'(commit_e));
                    retired_exp++;
                    acked = 1'b1;
                end else begin
                    check_eq("wait_hold", 32'(strobes()), 32'b00100);
                    check_eq("wait_no_err", 32'(mem_err), 32'd0);
                end
            end
            timed_out = !acked;
        end

        @(negedge clk);
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        #1;
        check_eq("back_ready", 32'(instr_ready), 32'd1);
        check_eq("retired", 32'(retired), 32'(16'(retired_exp)));
        check_eq("mem_err", 32'(mem_err), 32'(timed_out));
        if (timed_out)
            check_eq("abort_strobes", 32'(strobes()), 32'd0);
    endtask

    task automatic idle_cycle();
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        mem_ack     = 1'($urandom);
        #1;
        check_eq("idle_strobes", 32'(strobes()), 32'd0);
        check_eq("idle_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        zr          = 1'b0;
        ng          = 1'b0;
        mem_ack     = 1'b0;
        #3;
        check_eq("rst_ready", 32'(instr_ready), 32'd1);
        check_eq("rst_strobes", 32'(strobes()), 32'd0);
        check_eq("rst_ctrl", 32'({zx, nx, zy, ny, f, no}), 32'b101010);
        check_eq("rst_retired", 32'(retired), 32'd0);
        check_eq("rst_mem_err", 32'(mem_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_instr(16'h0015, 2, -1);          // @21
        do_instr(16'hE7D0, 2, -1);          // D=D+1
        do_instr(16'hEA84, 0, -1);          // 0;JLT, negative -> jump
        do_instr(16'hEA84, 1, -1);          // 0;JLT, zero -> no jump
        do_instr(16'hEA87, int'($urandom_range(0, 2)), -1); // 0;JMP
        do_instr(16'hE308, 2, 3);           // M=D, ack in 4th wait cycle
        do_instr(16'hE308, 2, -1);          // M=D, timeout
        do_instr(16'hE308, 1, 0);           // ack on first wait cycle
        do_instr(16'hE30F, 0, TMO - 1);     // ack on last allowed cycle

        // Reset while waiting on a memory write
        instr       = 16'hE328;             // AM=D
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check_eq("rst_mid_wm_before", 32'(write_m), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_wm", 32'(write_m), 32'd0);
        check_eq("rst_mid_la", 32'(load_a), 32'd0);
        check_eq("rst_mid_ready", 32'(instr_ready), 32'd1);
        check_eq("rst_mid_retired", 32'(retired), 32'd0);
        retired_exp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_instr(16'h0015, 2, -1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0)
                idle_cycle();
            do_instr(16'($urandom), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, TMO + 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
